sm3_blk_buf: RTL and testbench
==============================

SM3_BLK_BUF -- requirements
Module: sm3_blk_buf

Interface
REQ-001 SHALL have a single clock clk and an asynchronous active-low reset rst_n.
REQ-002 SHALL define parameter BEAT_WD (derived from sm3_cfg.v): 1 when SM3_INPT_DW_32 is set, 2 when SM3_INPT_DW_64 is set; it is the number of 32-bit words carried per input beat.
REQ-003 Port list:
  clk  in  1  clock
  rst_n  in  1  async active-low reset
  pad_otpt_d_i  in  `INPT_DW  padded data beat, first word in the MSBs
  pad_otpt_vld_i  in  1  beat valid, must be accepted unconditionally
  pad_otpt_lst_i  in  1  beat is the final word(s) of the padded message
  pad_otpt_ena_o  out  1  permission for the upstream padder to start input or a new block
  blk_d_o  out  512  assembled block, word0 in [511:480]
  blk_vld_o  out  1  a full block is presented
  blk_lst_o  out  1  presented block ends the message
  blk_rdy_i  in  1  downstream compression core accepts the block
  ovf_err_o  out  1  sticky: a beat was dropped
  lst_err_o  out  1  sticky: the last beat was not block-aligned

Function
REQ-004 SHALL hold two 16-word banks, each with state EMPTY, FILL or FULL, plus a per-bank word count (0..16) and a per-bank lst flag.
REQ-005 SHALL hold a write-bank select wr_sel and a read-bank select rd_sel; both reset to bank 0.
REQ-006 On each beat with pad_otpt_vld_i high and bank[wr_sel] not FULL, SHALL write BEAT_WD words at positions count..count+BEAT_WD-1, add BEAT_WD to count, and move an EMPTY bank to FILL.
REQ-007 SHALL set the bank to FULL when count reaches 16 after a write, latch pad_otpt_lst_i into the bank lst flag, reset count to 0, and toggle wr_sel, all on the same edge.
REQ-008 When pad_otpt_lst_i arrives with a post-write count other than 16, SHALL zero the remaining words, mark the bank FULL with lst=1, toggle wr_sel, and set lst_err_o.
REQ-009 A beat arriving while bank[wr_sel] is FULL SHALL be dropped and SHALL set ovf_err_o; bank state, count and data stay unchanged.
REQ-010 blk_vld_o SHALL be high exactly when bank[rd_sel] is FULL (registered state, no combinational path from inputs).
REQ-011 blk_d_o and blk_lst_o SHALL show bank[rd_sel] data and lst flag, and SHALL stay stable while blk_vld_o is high and blk_rdy_i is low.
REQ-012 When blk_vld_o and blk_rdy_i are both high, SHALL set bank[rd_sel] to EMPTY, clear its lst flag and toggle rd_sel at the clock edge.
REQ-013 A hand-off of one bank and a write to the other bank in the same cycle SHALL both take effect. This includes a write that completes the other bank.
REQ-014 blk_vld_o SHALL rise on the cycle after the clock edge that writes the 16th word, giving 1-cycle latency.
REQ-015 pad_otpt_ena_o SHALL be high only when no bank is FULL, decoded from registered state, so at most one in-flight beat lands after deassertion.
REQ-016 ovf_err_o and lst_err_o SHALL clear only on reset.

Reset
REQ-017 While rst_n is low, SHALL hold both banks EMPTY with all counts 0, lst flags 0, data 0, wr_sel=rd_sel=0, blk_vld_o=0, blk_lst_o=0, blk_d_o=0, errors 0 and pad_otpt_ena_o=1.
REQ-018 Assertion of rst_n mid-block SHALL discard all partial and full blocks; after release no stale block is presented.

Verification
REQ-019 "abc" message with BEAT_WD=1 and blk_rdy_i=1: words 0x61626380, fourteen zero words, then 0x00000018 with lst -> one cycle after the 16th word, blk_vld_o=1, blk_lst_o=1, blk_d_o[511:480]=0x61626380, blk_d_o[31:0]=0x00000018, all other bits 0, no error flags.
REQ-020 Two back-to-back 16-word blocks with blk_rdy_i=0 -> pad_otpt_ena_o falls the cycle after word 16; the second bank fills; blk_d_o holds block 1. After blk_rdy_i pulses, block 2 is presented the next cycle and pad_otpt_ena_o stays low until block 2 is accepted.
REQ-021 blk_rdy_i high on the same cycle the 16th word of the other bank is written -> both take effect, and blk_vld_o stays high continuously with block 2 data on the next cycle.
REQ-022 Five words 0x11111111..0x55555555 with lst on the fifth -> lst_err_o=1; the block shows those five words and eleven zero words, with blk_lst_o=1.
REQ-023 Both banks FULL and a further beat 0xDEADBEEF arrives -> beat dropped, ovf_err_o=1, both banks unchanged.
REQ-024 rst_n pulsed low after 7 words of a block -> all outputs at reset values; a fresh 16-word block afterwards is presented correctly with no residue.

Source files
------------

// File: rtl/sm3_blk_buf.sv
`default_nettype none
// ============================================================================
// Module      : sm3_blk_buf
// Description : Double-buffered 512-bit block assembler between the SM3
//               message padder and the compression core. Padded beats of
//               BEAT_WD 32-bit words are packed into one of two 16-word
//               banks. While one bank is being compressed, the other bank
//               fills. A bank that ends its message early is zero-filled.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   clock
//   rst_n          in   asynchronous active-low reset
//   pad_otpt_d_i   in   padded data beat (32*BEAT_WD), first word in the MSBs
//   pad_otpt_vld_i in   beat valid; a beat is never back-pressured
//   pad_otpt_lst_i in   beat carries the final word(s) of the message
//   pad_otpt_ena_o out  padder may start input or a new block
//   blk_d_o        out  assembled block, word0 in [511:480]
//   blk_vld_o      out  a full block is presented
//   blk_lst_o      out  presented block ends the message
//   blk_rdy_i      in   compression core accepts the presented block
//   ovf_err_o      out  sticky: a beat was dropped (both banks busy)
//   lst_err_o      out  sticky: the last beat was not block-aligned
// ============================================================================
module sm3_blk_buf #(
  // Words per input beat; follows the configured padder output width.
`ifdef SM3_INPT_DW_64
  parameter int unsigned BEAT_WD = 2
`else
  parameter int unsigned BEAT_WD = 1
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [32*BEAT_WD-1:0]   pad_otpt_d_i,
  input  logic                    pad_otpt_vld_i,
  input  logic                    pad_otpt_lst_i,
  output logic                    pad_otpt_ena_o,
  output logic [511:0]            blk_d_o,
  output logic                    blk_vld_o,
  output logic                    blk_lst_o,
  input  logic                    blk_rdy_i,
  output logic                    ovf_err_o,
  output logic                    lst_err_o
);

  localparam int unsigned c_inpt_dw = 32 * BEAT_WD;
  localparam logic [4:0]  c_beat    = 5'(BEAT_WD);
  localparam logic [4:0]  c_words   = 5'd16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } bank_st_t;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  bank_st_t                r_st [2];
  logic [1:0][4:0]         r_cnt;
  logic [1:0]              r_lst;
  logic [1:0][15:0][31:0]  r_dat;
  logic                    r_wr_sel;
  logic                    r_rd_sel;
  logic                    r_ovf_err;
  logic                    r_lst_err;

  // --------------------------------------------------------------------------
  // Next-state values
  // --------------------------------------------------------------------------
  bank_st_t                w_st_nxt [2];
  logic [1:0][4:0]         w_cnt_nxt;
  logic [1:0]              w_lst_nxt;
  logic [1:0][15:0][31:0]  w_dat_nxt;
  logic                    w_wr_sel_nxt;
  logic                    w_rd_sel_nxt;
  logic                    w_ovf_nxt;
  logic                    w_lst_err_nxt;

  logic                    w_wr_full;
  logic                    w_acc;
  logic                    w_hand;
  logic [4:0]              w_post;
  logic [3:0]              w_idx;

  assign w_wr_full = (r_st[r_wr_sel] == ST_FULL);
  assign w_acc     = pad_otpt_vld_i & ~w_wr_full;
  assign w_hand    = blk_vld_o & blk_rdy_i;
  // Word count of the write bank after this beat lands.
  assign w_post    = r_cnt[r_wr_sel] + c_beat;

  always_comb begin
    w_st_nxt      = r_st;
    w_cnt_nxt     = r_cnt;
    w_lst_nxt     = r_lst;
    w_dat_nxt     = r_dat;
    w_wr_sel_nxt  = r_wr_sel;
    w_rd_sel_nxt  = r_rd_sel;
    w_ovf_nxt     = r_ovf_err;
    w_lst_err_nxt = r_lst_err;
    w_idx         = '0;

    // A beat that finds its bank still waiting for the core has nowhere to
    // go; it is discarded and flagged, leaving the bank untouched.
    if (pad_otpt_vld_i && w_wr_full) begin
      w_ovf_nxt = 1'b1;
    end

    if (w_acc) begin
      for (int k = 0; k < int'(BEAT_WD); k++) begin
        w_idx = r_cnt[r_wr_sel][3:0] + 4'(k);
        w_dat_nxt[r_wr_sel][w_idx] = pad_otpt_d_i[c_inpt_dw-1-32*k -: 32];
      end

      if (w_post == c_words) begin
        w_st_nxt[r_wr_sel]  = ST_FULL;
        w_lst_nxt[r_wr_sel] = pad_otpt_lst_i;
        w_cnt_nxt[r_wr_sel] = '0;
        w_wr_sel_nxt        = ~r_wr_sel;
      end else if (pad_otpt_lst_i) begin
        // Message ended short of a block boundary: clear whatever a previous
        // block left in the tail so the core sees zeros, then close the bank.
        for (int i = 0; i < 16; i++) begin
          if (5'(i) >= w_post) begin
            w_dat_nxt[r_wr_sel][i] = '0;
          end
        end
        w_st_nxt[r_wr_sel]  = ST_FULL;
        w_lst_nxt[r_wr_sel] = 1'b1;
        w_cnt_nxt[r_wr_sel] = '0;
        w_wr_sel_nxt        = ~r_wr_sel;
        w_lst_err_nxt       = 1'b1;
      end else begin
        w_st_nxt[r_wr_sel]  = ST_FILL;
        w_cnt_nxt[r_wr_sel] = w_post;
      end
    end

    // The read bank is FULL whenever a hand-off happens and an accepted write
    // never targets a FULL bank, so both updates always hit different banks.
    if (w_hand) begin
      w_st_nxt[r_rd_sel]  = ST_EMPTY;
      w_lst_nxt[r_rd_sel] = 1'b0;
      w_rd_sel_nxt        = ~r_rd_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        r_st[b] <= ST_EMPTY;
      end
      r_cnt     <= '0;
      r_lst     <= '0;
      r_dat     <= '0;
      r_wr_sel  <= 1'b0;
      r_rd_sel  <= 1'b0;
      r_ovf_err <= 1'b0;
      r_lst_err <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        r_st[b] <= w_st_nxt[b];
      end
      r_cnt     <= w_cnt_nxt;
      r_lst     <= w_lst_nxt;
      r_dat     <= w_dat_nxt;
      r_wr_sel  <= w_wr_sel_nxt;
      r_rd_sel  <= w_rd_sel_nxt;
      r_ovf_err <= w_ovf_nxt;
      r_lst_err <= w_lst_err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all decoded from registered state only
  // --------------------------------------------------------------------------
  assign blk_vld_o      = (r_st[r_rd_sel] == ST_FULL);
  assign blk_lst_o      = r_lst[r_rd_sel];
  assign pad_otpt_ena_o = (r_st[0] != ST_FULL) && (r_st[1] != ST_FULL);
  assign ovf_err_o      = r_ovf_err;
  assign lst_err_o      = r_lst_err;

  for (genvar g = 0; g < 16; g++) begin : g_blk_word
    assign blk_d_o[511-32*g -: 32] = r_dat[r_rd_sel][g];
  end

endmodule
`default_nettype wire

// File: tb/tb_sm3_blk_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm3_blk_buf
// Description : Self-checking bench for sm3_blk_buf with one-word beats.
//               A vector table covers the "abc" block and a short message;
//               hand-written sequences cover back-to-back blocks, a
//               simultaneous hand-off/complete, overflow and mid-block reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sm3_blk_buf;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  pad_otpt_d_i;
  logic         pad_otpt_vld_i;
  logic         pad_otpt_lst_i;
  logic         pad_otpt_ena_o;
  logic [511:0] blk_d_o;
  logic         blk_vld_o;
  logic         blk_lst_o;
  logic         blk_rdy_i;
  logic         ovf_err_o;
  logic         lst_err_o;

  always #5 clk = ~clk;

  sm3_blk_buf #(.BEAT_WD(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pad_otpt_d_i   (pad_otpt_d_i),
    .pad_otpt_vld_i (pad_otpt_vld_i),
    .pad_otpt_lst_i (pad_otpt_lst_i),
    .pad_otpt_ena_o (pad_otpt_ena_o),
    .blk_d_o        (blk_d_o),
    .blk_vld_o      (blk_vld_o),
    .blk_lst_o      (blk_lst_o),
    .blk_rdy_i      (blk_rdy_i),
    .ovf_err_o      (ovf_err_o),
    .lst_err_o      (lst_err_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         vld;
    logic         lst;
    logic [31:0]  d;
    logic         rdy;
    logic         e_vld;
    logic         e_lst;
    logic         e_ena;
    logic         e_lerr;
    logic         chk_d;
    logic [511:0] e_d;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_vld, input logic e_lst,
                         input logic e_ena, input logic e_ovf, input logic e_lerr);
    chk({tag, ".vld"}, 512'(blk_vld_o), 512'(e_vld));
    chk({tag, ".lst"}, 512'(blk_lst_o), 512'(e_lst));
    chk({tag, ".ena"}, 512'(pad_otpt_ena_o), 512'(e_ena));
    chk({tag, ".ovf"}, 512'(ovf_err_o), 512'(e_ovf));
    chk({tag, ".lerr"}, 512'(lst_err_o), 512'(e_lerr));
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the consuming edge.
  task automatic step(input logic v, input logic [31:0] d, input logic l, input logic r);
    pad_otpt_vld_i = v;
    pad_otpt_d_i   = d;
    pad_otpt_lst_i = l;
    blk_rdy_i      = r;
    @(posedge clk);
    #1;
    pad_otpt_vld_i = 1'b0;
    pad_otpt_lst_i = 1'b0;
    blk_rdy_i      = 1'b0;
  endtask

  task automatic send_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) step(1'b1, base + 32'(i), 1'b0, 1'b0);
  endtask

  function automatic logic [511:0] blk_of(input logic [31:0] base);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = base + 32'(i);
    return r;
  endfunction

  task automatic add(input logic v, input logic l, input logic [31:0] d, input logic r,
                     input logic ev, input logic el, input logic ee, input logic elerr,
                     input logic cd, input logic [511:0] ed);
    vec_t t;
    t.vld = v; t.lst = l; t.d = d; t.rdy = r;
    t.e_vld = ev; t.e_lst = el; t.e_ena = ee; t.e_lerr = elerr;
    t.chk_d = cd; t.e_d = ed;
    tbl.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [511:0] abc_exp;
    logic [511:0] lerr_exp;
    logic [31:0]  d;
    logic         last;

    abc_exp  = {32'h61626380, 448'd0, 32'h00000018};
    lerr_exp = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                32'h55555555, 352'd0};

    // "abc" block with the core always ready, then the hand-off cycle.
    for (int i = 0; i < 16; i++) begin
      d    = (i == 0) ? 32'h61626380 : ((i == 15) ? 32'h00000018 : 32'h0);
      last = (i == 15);
      add(1'b1, last, d, 1'b1, last, last, !last, 1'b0, last, abc_exp);
    end
    add(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    // Five-word message ending unaligned, written over a bank with stale data.
    for (int k = 1; k <= 5; k++) begin
      d    = 32'(32'h11111111 * k);
      last = (k == 5);
      add(1'b1, last, d, 1'b0, last, last, !last, last, last, lerr_exp);
    end
    add(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);

    rst_n          = 1'b0;
    pad_otpt_d_i   = '0;
    pad_otpt_vld_i = 1'b0;
    pad_otpt_lst_i = 1'b0;
    blk_rdy_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("reset.d", blk_d_o, '0);
    rst_n = 1'b1;

    // Back-to-back blocks with the core stalled.
    send_words(32'h10000000, 15);
    chk_out("b2b.w15", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_words(32'h1000000F, 1);
    chk_out("b2b.w16", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b.d1", blk_d_o, blk_of(32'h10000000));
    send_words(32'h20000000, 16);
    chk_out("b2b.full2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b.hold1", blk_d_o, blk_of(32'h10000000));
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk_out("b2b.take1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b.d2", blk_d_o, blk_of(32'h20000000));
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk_out("b2b.wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b.hold2", blk_d_o, blk_of(32'h20000000));
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk_out("b2b.take2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Hand-off of one bank on the same edge that completes the other.
    send_words(32'h30000000, 16);
    send_words(32'h40000000, 15);
    chk_out("sim.pre", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sim.d1", blk_d_o, blk_of(32'h30000000));
    step(1'b1, 32'h4000000F, 1'b0, 1'b1);
    chk_out("sim.both", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sim.d2", blk_d_o, blk_of(32'h40000000));
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk_out("sim.done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      step(tbl[i].vld, tbl[i].d, tbl[i].lst, tbl[i].rdy);
      chk_out($sformatf("tbl%0d", i), tbl[i].e_vld, tbl[i].e_lst, tbl[i].e_ena,
              1'b0, tbl[i].e_lerr);
      if (tbl[i].chk_d) chk($sformatf("tbl%0d.d", i), blk_d_o, tbl[i].e_d);
    end

    // Overflow: both banks full, a further beat must be dropped.
    send_words(32'h50000000, 16);
    send_words(32'h60000000, 16);
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    chk_out("ovf.drop", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ovf.d1", blk_d_o, blk_of(32'h50000000));
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("ovf.d2", blk_d_o, blk_of(32'h60000000));
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk_out("ovf.done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of a block.
    send_words(32'h70000000, 7);
    rst_n = 1'b0;
    #2;
    chk_out("mrst.async", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mrst.d", blk_d_o, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_words(32'h80000000, 15);
    chk_out("mrst.w15", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_words(32'h8000000F, 1);
    chk_out("mrst.w16", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mrst.blk", blk_d_o, blk_of(32'h80000000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
